// File: rtl/add_sub_pipe_pkg.sv
// Shared types and limits for the add_sub_pipe elastic adder/subtractor.
package add_sub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDS = 2'b10,
    OP_SUBS = 2'b11
  } op_e;

  localparam int MAX_STAGES = 8;
  localparam int MIN_STAGES = 1;

endpackage

// File: rtl/add_sub_pipe_if.sv
// Producer/consumer handshake bundle for add_sub_pipe; the DUT takes the slave side.
interface add_sub_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/add_sub_pipe_stage.sv
// One elastic register slot: valid bit plus payload, loads when empty or draining.
module add_sub_stage #(
  parameter int PW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [PW-1:0] up_data,
  input  logic          dn_ready,
  output logic          dn_valid,
  output logic [PW-1:0] dn_data
);

  logic          valid_q, valid_d;
  logic [PW-1:0] data_q, data_d;
  logic          advance;

  always_comb begin
    advance = !valid_q || dn_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (advance) begin
      valid_d = up_valid;
      // payload only changes on a real transfer so the output holds while stalled
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;

endmodule

// File: rtl/add_sub_pipe.sv
// Elastic pipelined adder/subtractor with zero flag.
// Define ADD_SUB_SAT_EN to enable saturating add/subtract on opcodes 10/11.
module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  add_sub_pipe_if.slave bus
);

  localparam int RW = WIDTH + 1;
  // out-of-range depths are clamped into the supported range
  localparam int DEPTH = (STAGES > MAX_STAGES) ? MAX_STAGES :
                         ((STAGES < MIN_STAGES) ? MIN_STAGES : STAGES);

  typedef struct packed {
    logic [RW-1:0] result;
    logic          zero;
  } payload_t;

  localparam int PW = $bits(payload_t);

  op_e           op;
  logic [RW-1:0] sum;
  logic [RW-1:0] diff;
  logic [RW-1:0] res;
  payload_t      in_pl;

  always_comb begin
    op   = op_e'(bus.op);
    sum  = {1'b0, bus.a} + {1'b0, bus.b};
    diff = {1'b0, bus.a} - {1'b0, bus.b};
    res  = sum;
    case (op)
      OP_ADD:  res = sum;
      OP_SUB:  res = diff;
`ifdef ADD_SUB_SAT_EN
      OP_ADDS: res = sum[WIDTH]  ? {1'b1, {WIDTH{1'b1}}} : sum;
      OP_SUBS: res = diff[WIDTH] ? {1'b1, {WIDTH{1'b0}}} : diff;
`else
      OP_ADDS: res = sum;
      OP_SUBS: res = diff;
`endif
    endcase
    in_pl.result = res;
    in_pl.zero   = (res[WIDTH-1:0] == '0);
  end

  logic [DEPTH-1:0] vld;
  payload_t         dat [DEPTH];
  logic [DEPTH:0]   rdy;

  // rdy[k] is the "slot k can take data" signal; rdy[DEPTH] is the consumer
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = bus.out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = !vld[k] || rdy[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic     up_v;
    payload_t up_d;

    if (k == 0) begin : g_head
      assign up_v = bus.in_valid && !rst;
      assign up_d = in_pl;
    end else begin : g_body
      assign up_v = vld[k-1];
      assign up_d = dat[k-1];
    end

    add_sub_stage #(
      .PW(PW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_v),
      .up_data  (up_d),
      .dn_ready (rdy[k+1]),
      .dn_valid (vld[k]),
      .dn_data  (dat[k])
    );
  end

  assign bus.in_ready  = rdy[0] && !rst;
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.result    = dat[DEPTH-1].result;
  assign bus.zero      = dat[DEPTH-1].zero;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe (WIDTH=8, STAGES=2) with a queue-based reference model.
module tb_add_sub_pipe;

  localparam int W = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  add_sub_pipe_if #(.WIDTH(W)) bus ();

  add_sub_pipe #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int sb_pops = 0;

  typedef struct {
    logic [W:0] res;
    logic       zero;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  bit         sb_en = 1'b0;
  bit         stall_prev = 1'b0;
  logic [W:0] stall_res;
  logic       stall_zero;

`ifdef ADD_SUB_SAT_EN
  localparam logic [8:0] E_ADDS = 9'h1FF;
  localparam logic [8:0] E_SUBS = 9'h100;
  localparam logic       Z_SUBS = 1'b1;
`else
  localparam logic [8:0] E_ADDS = 9'h104;
  localparam logic [8:0] E_SUBS = 9'h1FC;
  localparam logic       Z_SUBS = 1'b0;
`endif

  // Reference: plain integer arithmetic on the opcode rules
  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    int   r;
    int   maxv;
    maxv = (1 << W) - 1;
    case (op)
      0: r = a + b;
      1: r = a - b;
`ifdef ADD_SUB_SAT_EN
      2: r = (a + b > maxv) ? ((1 << W) + maxv) : (a + b);
      3: r = (a < b) ? (1 << W) : (a - b);
`else
      2: r = a + b;
      3: r = a - b;
`endif
      default: r = 0;
    endcase
    if (r < 0) r = r + (1 << (W + 1));
    e.res  = r[W:0];
    e.zero = ((r % (1 << W)) == 0);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: order/value of every transfer plus hold-while-stalled
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (stall_prev) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== stall_res || bus.zero !== stall_zero) begin
          errors++;
          $display("FAIL stall_hold: got v=%b r=%h z=%b want v=1 r=%h z=%b",
                   bus.out_valid, bus.result, bus.zero, stall_res, stall_zero);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        sb_pops++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got r=%h with no pending op, want none", bus.result);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.result !== mon_e.res || bus.zero !== mon_e.zero) begin
            errors++;
            $display("FAIL sb_result: got r=%h z=%b want r=%h z=%b",
                     bus.result, bus.zero, mon_e.res, mon_e.zero);
          end
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
        exp_q.push_back(model(int'(bus.a), int'(bus.b), int'(bus.op)));
      stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      stall_res  = bus.result;
      stall_zero = bus.zero;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 2'd0);
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 9'h000 || bus.zero !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b r=%h z=%b rdy=%b want 0/000/0/0",
               bus.out_valid, bus.result, bus.zero, bus.in_ready);
    end
    cyc();
    rst = 1'b0;
    sb_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [9] = '{8'd200, 8'd5, 8'd7, 8'd255, 8'd0, 8'd250, 8'd3, 8'd100, 8'd9};
    logic [7:0] tb [9] = '{8'd100, 8'd10, 8'd7, 8'd255, 8'd1, 8'd10, 8'd7, 8'd50, 8'd4};
    logic [1:0] to [9] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [8:0] tr [9] = '{9'h12C, 9'h1FB, 9'h000, 9'h1FE, 9'h1FF, E_ADDS, E_SUBS, 9'h096, 9'h005};
    logic       tz [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Z_SUBS, 1'b0, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      drive(1'b1, ta[i], tb[i], to[i]);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      cyc();
      drive(1'b0, 8'd0, 8'd0, 2'd0);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir_early[%0d]: out_valid got %b want 0 one cycle after accept", i, bus.out_valid);
      end
      cyc();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== tr[i] || bus.zero !== tz[i]) begin
        errors++;
        $display("FAIL dir_result[%0d]: got v=%b r=%h z=%b want v=1 r=%h z=%b",
                 i, bus.out_valid, bus.result, bus.zero, tr[i], tz[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] got[$];
    cyc();
    bus.out_ready = 1'b0;
    drive(1'b1, 8'd1, 8'd1, 2'd0);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept1: in_ready got %b want 1", bus.in_ready);
    end
    cyc();
    drive(1'b1, 8'd2, 8'd2, 2'd0);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept2: in_ready got %b want 1", bus.in_ready);
    end
    cyc();
    drive(1'b1, 8'd3, 8'd3, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 9'd2) begin
        errors++;
        $display("FAIL bp_full[%0d]: got rdy=%b v=%b r=%h want rdy=0 v=1 r=002",
                 i, bus.in_ready, bus.out_valid, bus.result);
      end
      cyc();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_simultaneous: in_ready got %b want 1 when output drains", bus.in_ready);
    end
    if (bus.out_valid === 1'b1) got.push_back(bus.result);
    cyc();
    drive(1'b0, 8'd0, 8'd0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) got.push_back(bus.result);
      cyc();
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d results want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== 9'(2 * (i + 1))) begin
          errors++;
          $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 9'(2 * (i + 1)));
        end
      end
    end
  endtask

  task automatic test_throughput();
    logic [8:0] vals[$];
    int first = -1;
    int last = -1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      cyc();
      if (c < 10) drive(1'b1, 8'(c), 8'(c), 2'd0);
      else        drive(1'b0, 8'd0, 8'd0, 2'd0);
      @(negedge clk);
      if (c < 10) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL tp_in_ready[%0d]: got %b want 1", c, bus.in_ready);
        end
      end
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        vals.push_back(bus.result);
      end
    end
    checks++;
    if (vals.size() != 10 || first != 2 || last != 11) begin
      errors++;
      $display("FAIL tp_timing: got n=%0d first=%0d last=%0d want n=10 first=2 last=11",
               vals.size(), first, last);
    end
    for (int i = 0; i < vals.size() && i < 10; i++) begin
      checks++;
      if (vals[i] !== 9'(2 * i)) begin
        errors++;
        $display("FAIL tp_value[%0d]: got %h want %h", i, vals[i], 9'(2 * i));
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    cyc();
    drive(1'b1, 8'd10, 8'd20, 2'd0);
    cyc();
    drive(1'b1, 8'd30, 8'd40, 2'd0);
    cyc();
    drive(1'b0, 8'd0, 8'd0, 2'd0);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: out_valid got %b want 1", bus.out_valid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 9'h000 || bus.zero !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got v=%b r=%h z=%b rdy=%b want 0/000/0/0",
               bus.out_valid, bus.result, bus.zero, bus.in_ready);
    end
    #1 rst = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: in_ready got %b want 1", bus.in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale[%0d]: out_valid got %b want 0", i, bus.out_valid);
      end
      cyc();
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    int waited;
    int start_pops;
    start_pops = sb_pops;
    for (int i = 0; i < 300; i++) begin
      cyc();
      ra = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00) : 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00) : 8'($urandom);
      drive(($urandom_range(0, 9) < 7), ra, rb, 2'($urandom_range(0, 3)));
      bus.out_ready = ($urandom_range(0, 9) < 7);
    end
    cyc();
    drive(1'b0, 8'd0, 8'd0, 2'd0);
    bus.out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      cyc();
      waited++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: %0d results outstanding want 0", exp_q.size());
    end
    checks++;
    if (sb_pops - start_pops < 50) begin
      errors++;
      $display("FAIL rand_volume: got %0d results want at least 50", sb_pops - start_pops);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
